// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage data-bus sequencer for loads and stores
module mem_access_ctrl #(
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_is_store,
    input  logic [31:0] m_addr,
    input  logic [2:0]  m_size,
    input  logic [31:0] m_wdata,
    input  logic        pipe_advance,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        mem_stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter wide enough to hold WATCHDOG_CYCLES; a zero setting disables it.
    localparam int              WD_W   = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);
    localparam logic            WD_EN  = (WATCHDOG_CYCLES != 0);

    state_t state;
    state_t state_nxt;

    logic        size_bad;
    logic        req_go;
    logic        capture;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;

    logic [31:0] lat_addr;
    logic [2:0]  lat_size;
    logic [3:0]  lat_strobe;
    logic [31:0] lat_data;
    logic        lat_is_store;
    logic [31:0] hold_data;

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_nxt;
    logic            waiting;

    // Alignment check and byte-lane placement of the incoming memory-stage access.
    always_comb begin
        size_bad   = 1'b0;
        req_strobe = 4'b0000;
        case (m_size)
            3'd0: begin
                size_bad   = 1'b0;
                req_strobe = 4'b0001 << m_addr[1:0];
            end
            3'd1: begin
                size_bad   = m_addr[0];
                req_strobe = 4'b0011 << m_addr[1:0];
            end
            3'd2: begin
                size_bad   = |m_addr[1:0];
                req_strobe = 4'b1111;
            end
            default: begin
                size_bad   = 1'b1;
                req_strobe = 4'b0000;
            end
        endcase
        if (!m_is_store) begin
            req_strobe = 4'b0000;
        end
        req_data = m_wdata << {m_addr[1:0], 3'b000};
        misalign = (state == S_IDLE) && m_valid && size_bad;
        req_go   = (state == S_IDLE) && m_valid && !size_bad;
    end

    // Next-state and bus/pipeline outputs; IDLE drives the bus straight from the
    // memory stage, later states replay the latched copy so fields stay stable.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        dreq_valid  = 1'b0;
        dreq_addr   = lat_addr;
        dreq_size   = lat_size;
        dreq_strobe = lat_strobe;
        dreq_data   = lat_data;
        mem_stall   = 1'b0;
        case (state)
            S_IDLE: begin
                dreq_valid  = req_go;
                dreq_addr   = m_addr;
                dreq_size   = m_size;
                dreq_strobe = req_strobe;
                dreq_data   = req_data;
                mem_stall   = req_go;
                if (req_go) begin
                    if (dresp_addr_ok && dresp_data_ok) begin
                        state_nxt = S_DONE;
                        capture   = 1'b1;
                    end else if (dresp_addr_ok) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                dreq_valid = 1'b1;
                mem_stall  = 1'b1;
                if (dresp_addr_ok && dresp_data_ok) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end else if (dresp_addr_ok) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                mem_stall = 1'b1;
                if (dresp_data_ok) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end
            end
            S_DONE: begin
                if (pipe_advance) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the request as it is issued so retries in ADDR replay identical fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr     <= '0;
            lat_size     <= '0;
            lat_strobe   <= '0;
            lat_data     <= '0;
            lat_is_store <= 1'b0;
        end else if (req_go) begin
            lat_addr     <= m_addr;
            lat_size     <= m_size;
            lat_strobe   <= req_strobe;
            lat_data     <= req_data;
            lat_is_store <= m_is_store;
        end
    end

    // Holding register: only a completing transaction updates it, so stray data_ok is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
        end else if (capture) begin
            hold_data <= dresp_data;
        end
    end

    assign ld_valid = (state == S_DONE) && !lat_is_store;
    assign ld_data  = hold_data;

    assign waiting = (state == S_ADDR) || (state == S_DATA);
    assign wd_nxt  = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1);

    // Watchdog: count waiting cycles, saturate, and raise a sticky flag at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            bus_timeout <= 1'b0;
        end else begin
            if (WD_EN && waiting && ((state_nxt == S_ADDR) || (state_nxt == S_DATA))) begin
                wd_cnt <= wd_nxt;
            end else begin
                wd_cnt <= '0;
            end
            if (WD_EN && waiting && (wd_nxt == WD_MAX)) begin
                bus_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the memory-stage data-bus transaction for loads and stores.
- Issues exactly one dbus request per memory instruction and holds the pipeline until data_ok returns.
- Captures load data into a holding register, so the writeback stage sees a stable word regardless of other stalls.
- Sits between the memory stage and the dbus_req_t/dbus_resp_t interface; its outputs feed the M→W pipeline register and hazard unit.

Parameters:
WATCHDOG_CYCLES, 1023, cycles spent waiting in ADDR/DATA before bus_timeout sets; 0 disables the watchdog

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
m_valid  in  1  memory-stage instruction valid and requires a bus access
m_is_store  in  1  1 = store, 0 = load
m_addr  in  32  byte address
m_size  in  3  msize_t: 0 = byte, 1 = half, 2 = word; other codes invalid
m_wdata  in  32  store data, right-aligned
pipe_advance  in  1  downstream accepts M→W this cycle
dreq_valid  out  1  dbus_req_t.valid
dreq_addr  out  32  dbus_req_t.addr
dreq_size  out  3  dbus_req_t.size
dreq_strobe  out  4  dbus_req_t.strobe
dreq_data  out  32  dbus_req_t.data
dresp_addr_ok  in  1  dbus_resp_t.addr_ok
dresp_data_ok  in  1  dbus_resp_t.data_ok
dresp_data  in  32  dbus_resp_t.data
mem_stall  out  1  hold memory stage and all earlier stages
ld_valid  out  1  held load word is valid for writeback
ld_data  out  32  held load word, raw bus data, no extension
misalign  out  1  current m_ access is misaligned or has an invalid size; no request is issued
bus_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE, every registered output 0, holding register 0, watchdog counter 0, bus_timeout 0.
- Misaligned condition:
  - half access with addr[0] set;
  - word access with addr[1:0] nonzero;
  - m_size greater than 2.
  - misalign is combinational and asserts only when m_valid is set in IDLE.
  - In that case: dreq_valid 0, mem_stall 0, no state change.
- Strobe for stores:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - loads: 0
- dreq_data = m_wdata << (8*addr[1:0]).
- State IDLE:
  - dreq_valid = m_valid & !misalign; request fields driven combinationally from m_*.
  - If the request is active:
    - request fields are latched;
    - addr_ok & data_ok → DONE, data captured;
    - addr_ok only → DATA;
    - neither → ADDR.
  - mem_stall = request active.
- State ADDR:
  - dreq_valid 1; request fields come from latched registers and stay stable until addr_ok.
  - addr_ok & data_ok → DONE, data captured; addr_ok only → DATA.
  - mem_stall 1.
- State DATA:
  - dreq_valid 0; mem_stall 1.
  - data_ok → DONE, data captured.
- State DONE:
  - dreq_valid 0, mem_stall 0.
  - ld_valid = !latched is_store; ld_data = holding register.
  - pipe_advance → IDLE; otherwise stay in DONE.
  - No reissue while in DONE, so a stalled store is never duplicated.
- Minimum latency: request and data_ok in cycle 0, stall released in cycle 1, a one-cycle penalty.
- Stray responses:
  - data_ok in IDLE without addr_ok in the same cycle is ignored.
  - data_ok in DONE is ignored.
  - This covers a response to a transaction abandoned by reset.
- Watchdog:
  - Counter increments each cycle in ADDR or DATA, saturating.
  - Clears on entry to DONE or IDLE.
  - Reaching WATCHDOG_CYCLES sets bus_timeout, which holds until reset.
  - The FSM does not abort.
- Reset mid-transaction: next state IDLE, holding register cleared, outstanding request dropped.

Test Plan:
1. Load word at addr 0x80000010, with addr_ok and data_ok in the same cycle and data 0xDEADBEEF → dreq_valid pulses 1 cycle, mem_stall high 1 cycle, then ld_valid=1 and ld_data=0xDEADBEEF; with pipe_advance=1 the FSM returns to IDLE.
2. Store byte at addr 0x...03, wdata 0x000000AB, with addr_ok delayed 3 cycles and data_ok 2 cycles later → dreq fields constant for 4 cycles, strobe 4'b1000, data 0xAB000000, mem_stall high 6 cycles, ld_valid stays 0.
3. Load completes while pipe_advance=0 for 5 cycles → FSM stays in DONE, dreq_valid stays 0, ld_data stays stable, and exactly one request is observed.
4. Half access at addr 0x...01, and separately m_size=3 → misalign=1, dreq_valid=0, mem_stall=0.
5. WATCHDOG_CYCLES=8 with addr_ok never asserted → bus_timeout rises after 8 waiting cycles; reset clears it and returns the FSM to IDLE; a stray data_ok in the next cycle is ignored.
